// File: rtl/cache_types.sv
// Shared types and default geometry for the L1 data cache.
// Derived widths follow the word-offset / index / tag split of a 32-bit byte address.
package cache_types;
  localparam int SETS_D   = 64;
  localparam int WAYS_D   = 2;
  localparam int BLOCKS_D = 4;
  localparam int OFF_W    = $clog2(BLOCKS_D);
  localparam int IDX_W    = $clog2(SETS_D);
  localparam int TAG_W    = 32 - IDX_W - OFF_W - 2;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef logic [BLOCKS_D-1:0][31:0] line_t;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
endpackage

// File: rtl/cache_lru.sv
// Per-set LRU tracking with age counters: 0 = most recent, WAYS-1 = least recent.
// Ages in a set always form a permutation, so exactly one way carries the oldest age.
module cache_lru #(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int IW   = $clog2(SETS),
  parameter int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] set_idx,
  input  logic [WW-1:0] way,
  input  logic          update,
  output logic [WW-1:0] lru_way
);
  logic [WW-1:0] age [SETS][WAYS];

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set_idx][w] == WW'(WAYS - 1)) lru_way = WW'(w);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WW'(w);
    end else if (update) begin
      // Touched way becomes youngest; only ways younger than it age by one.
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == way) age[set_idx][w] <= '0;
        else if (age[set_idx][w] < age[set_idx][way]) age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_module.sv
// Set-associative write-back, write-allocate L1 data cache with LRU replacement.
// Lookup is combinational; a miss stalls the requester through writeback and fill.
module cache_module
  import cache_types::*;
#(
  parameter int SETS   = SETS_D,
  parameter int WAYS   = WAYS_D,
  parameter int BLOCKS = BLOCKS_D
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [3:0]            byte_mask,
  input  logic [31:0]           write_word,
  output logic                  miss,
  output logic [31:0]           read_word,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic [BLOCKS*32-1:0]  mem_read_block,
  output logic                  mem_we,
  output logic [BLOCKS*32-1:0]  mem_write_block,
  input  logic                  mem_miss
);
  localparam int OW = $clog2(BLOCKS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - OW - 2;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  tag_entry_t dir   [SETS][WAYS];
  line_t      lines [SETS][WAYS];
  state_t     state, state_nx;

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] atag;
  logic          addr_unused;
  logic          hit, found_free, victim_dirty;
  logic [WW-1:0] hit_way, victim, lru_way;
  logic [31:0]   merged, victim_addr, blk_addr;
  logic          fill_en, wr_en, lru_upd;

  assign off         = addr[OW+1:2];
  assign idx         = addr[OW+IW+1:OW+2];
  assign atag        = addr[31:OW+IW+2];
  assign addr_unused = ^addr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && dir[idx][w].valid && dir[idx][w].tag == atag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
  end

  // Lowest-index invalid way wins; otherwise evict the LRU way.
  always_comb begin
    found_free = 1'b0;
    victim     = lru_way;
    for (int w = 0; w < WAYS; w++)
      if (!found_free && !dir[idx][w].valid) begin
        found_free = 1'b1;
        victim     = WW'(w);
      end
  end

  assign victim_dirty    = dir[idx][victim].valid && dir[idx][victim].dirty;
  assign victim_addr     = {dir[idx][victim].tag, idx, {(OW+2){1'b0}}};
  assign blk_addr        = {addr[31:OW+2], {(OW+2){1'b0}}};
  assign mem_write_block = lines[idx][victim];
  assign read_word       = lines[idx][hit_way][off];
  assign miss            = req && (state != IDLE || !hit);

  always_comb begin
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = byte_mask[b] ? write_word[8*b +: 8] : read_word[8*b +: 8];
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    fill_en  = 1'b0;
    wr_en    = 1'b0;
    lru_upd  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            lru_upd = 1'b1;
            wr_en   = we;
          end else if (victim_dirty) begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = victim_addr;
            state_nx = mem_miss ? WRITEBACK : FILL;
          end else begin
            mem_req  = 1'b1;
            mem_addr = blk_addr;
            if (mem_miss) state_nx = FILL;
            else          fill_en  = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = victim_addr;
        if (!mem_miss) state_nx = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = blk_addr;
        if (!mem_miss) begin
          fill_en  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset takes priority over fills and write hits; line data itself is never cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          dir[s][w].valid <= 1'b0;
          dir[s][w].dirty <= 1'b0;
        end
    end else begin
      state <= state_nx;
      if (fill_en) begin
        dir[idx][victim]   <= '{valid: 1'b1, dirty: 1'b0, tag: atag};
        lines[idx][victim] <= mem_read_block;
      end
      if (wr_en) begin
        lines[idx][hit_way][off] <= merged;
        dir[idx][hit_way].dirty  <= 1'b1;
      end
    end
  end

  cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clock   (clock),
    .reset   (reset),
    .set_idx (idx),
    .way     (hit_way),
    .update  (lru_upd),
    .lru_way (lru_way)
  );
endmodule

// File: tb/tb_cache_module.sv
// Bench for cache_module: a flat word-addressed memory model predicts every read,
// an L2 responder with variable latency serves the block port, and a monitor scores reads.
module tb_cache_module;
  localparam int BLOCKS = 4;

  logic                 clock = 1'b0;
  logic                 reset, req, we;
  logic [31:0]          addr, write_word, read_word, mem_addr;
  logic [3:0]           byte_mask;
  logic                 miss, mem_req, mem_we;
  logic                 mem_miss = 1'b1;
  logic [BLOCKS*32-1:0] mem_read_block = '0;
  logic [BLOCKS*32-1:0] mem_write_block;

  always #5 clock = ~clock;

  cache_module dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
    .byte_mask(byte_mask), .write_word(write_word), .miss(miss),
    .read_word(read_word), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_read_block(mem_read_block), .mem_we(mem_we),
    .mem_write_block(mem_write_block), .mem_miss(mem_miss)
  );

  logic [31:0] l2      [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_q   [$];

  int compared = 0, mismatched = 0;
  int req_cycles = 0, wb_cycles = 0, fills = 0, wbs = 0;
  int lat_next = 3, cnt = 0;
  bit rand_lat = 1'b0, busy = 1'b0;
  logic [31:0]          last_fill = '0, last_wb_addr = '0;
  logic [BLOCKS*32-1:0] last_wb_blk = '0;

  function automatic logic [31:0] dflt(int unsigned wa);
    return (wa * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] l2_rd(int unsigned wa);
    if (l2.exists(wa)) return l2[wa];
    return dflt(wa);
  endfunction
  function automatic logic [31:0] ref_rd(int unsigned wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return dflt(wa);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // L2 responder and read monitor, both away from the active edge.
  always @(negedge clock) begin
    if (mem_req) begin
      req_cycles++;
      if (mem_we) wb_cycles++;
      if (!busy) begin
        busy = 1'b1;
        cnt  = rand_lat ? int'($urandom_range(0, 3)) : lat_next;
      end else if (cnt != 0) cnt--;
      mem_miss = (cnt != 0);
      for (int i = 0; i < BLOCKS; i++)
        mem_read_block[32*i +: 32] = l2_rd(int'(mem_addr >> 2) + i);
    end else begin
      busy     = 1'b0;
      mem_miss = 1'b1;
    end
    if (req && !we && !miss && !reset) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL read_unexpected: got 0x%08h, expected no read", read_word);
      end else check("read_word", read_word, exp_q.pop_front());
    end
  end

  always @(posedge clock) begin
    if (mem_req && !mem_miss && !reset) begin
      busy = 1'b0;
      if (mem_we) begin
        wbs++;
        last_wb_addr = mem_addr;
        last_wb_blk  = mem_write_block;
        for (int i = 0; i < BLOCKS; i++)
          l2[int'(mem_addr >> 2) + i] = mem_write_block[32*i +: 32];
      end else begin
        fills++;
        last_fill = mem_addr;
      end
    end
  end

  task automatic issue(bit w, logic [31:0] a, logic [3:0] m, logic [31:0] d, bit commit);
    logic [31:0] o;
    req = 1'b1; we = w; addr = a; byte_mask = m; write_word = d;
    if (commit) begin
      o = ref_rd(int'(a >> 2));
      if (!w) exp_q.push_back(o);
      else begin
        for (int b = 0; b < 4; b++) if (m[b]) o[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a >> 2)] = o;
      end
    end
  endtask

  task automatic finish_access(string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (miss && n < 200);
    if (miss) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: miss still 1 after %0d cycles, required 0", name, n);
    end
    @(posedge clock); #1;
    req = 1'b0;
  endtask

  task automatic access(bit w, logic [31:0] a, logic [3:0] m, logic [31:0] d, string name);
    issue(w, a, m, d, 1'b1);
    finish_access(name);
  endtask

  // Lost dirty lines are expected after reset: the model resynchronises to L2.
  task automatic do_reset();
    reset = 1'b1; req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    ref_mem = l2;
  endtask

  int r0, w0, f0;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; byte_mask = '0; write_word = '0;
    l2[32'h40] = 32'h00; l2[32'h41] = 32'h11; l2[32'h42] = 32'h22; l2[32'h43] = 32'h33;
    ref_mem = l2;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_miss", {31'b0, miss}, 0);
    check("reset_mem_req", {31'b0, mem_req}, 0);

    // Cold read miss, then a hit on a neighbouring word.
    issue(1'b0, 32'h100, 4'h0, 32'h0, 1'b1);
    #1;
    check("t1_miss_same_cycle", {31'b0, miss}, 1);
    check("t1_mem_req", {31'b0, mem_req}, 1);
    check("t1_mem_we", {31'b0, mem_we}, 0);
    check("t1_mem_addr", mem_addr, 32'h100);
    finish_access("t1_read");
    r0 = req_cycles;
    access(1'b0, 32'h104, 4'h0, 32'h0, "t1_reread");
    check("t1_no_mem_traffic", req_cycles - r0, 0);

    // Write hit with partial byte mask.
    r0 = req_cycles;
    access(1'b1, 32'h104, 4'b0011, 32'hDEADBEEF, "t2_write");
    access(1'b0, 32'h104, 4'h0, 32'h0, "t2_read");
    check("t2_no_mem_traffic", req_cycles - r0, 0);

    // LRU choice with a clean victim.
    access(1'b0, 32'h100, 4'h0, 32'h0, "t3_a");
    access(1'b0, 32'h500, 4'h0, 32'h0, "t3_b");
    access(1'b0, 32'h100, 4'h0, 32'h0, "t3_c");
    w0 = wb_cycles;
    access(1'b0, 32'h900, 4'h0, 32'h0, "t3_d");
    check("t3_no_writeback", wb_cycles - w0, 0);
    check("t3_fill_addr", last_fill, 32'h900);
    r0 = req_cycles;
    access(1'b0, 32'h100, 4'h0, 32'h0, "t3_e");
    check("t3_100_hits", req_cycles - r0, 0);
    r0 = req_cycles;
    access(1'b0, 32'h500, 4'h0, 32'h0, "t3_f");
    check("t3_500_evicted", {31'b0, req_cycles != r0}, 1);

    // Dirty victim writeback followed by a fill.
    do_reset();
    access(1'b1, 32'h100, 4'hF, 32'hCAFEF00D, "t4_write");
    access(1'b0, 32'h500, 4'h0, 32'h0, "t4_b");
    w0 = wbs;
    issue(1'b0, 32'h900, 4'h0, 32'h0, 1'b1);
    #1;
    check("t4_mem_we", {31'b0, mem_we}, 1);
    check("t4_wb_addr_comb", mem_addr, 32'h100);
    check("t4_wb_word_comb", mem_write_block[31:0], 32'hCAFEF00D);
    finish_access("t4_c");
    check("t4_wb_count", wbs - w0, 1);
    check("t4_wb_addr", last_wb_addr, 32'h100);
    check("t4_wb_word", last_wb_blk[31:0], 32'hCAFEF00D);
    check("t4_fill_addr", last_fill, 32'h900);
    r0 = req_cycles;
    access(1'b0, 32'h100, 4'h0, 32'h0, "t4_refetch");
    check("t4_refetch_missed", {31'b0, req_cycles != r0}, 1);

    // Write miss on an untouched set.
    f0 = fills; w0 = wb_cycles;
    access(1'b1, 32'h2000, 4'b0101, 32'h12345678, "t5_write");
    check("t5_one_fill", fills - f0, 1);
    check("t5_no_writeback", wb_cycles - w0, 0);
    r0 = req_cycles;
    access(1'b1, 32'h2000, 4'b1010, 32'hA1B2C3D4, "t5_write2");
    check("t5_second_hits", req_cycles - r0, 0);
    access(1'b0, 32'h2000, 4'h0, 32'h0, "t5_read");

    // Reset in the middle of a stalled fill.
    lat_next = 20;
    issue(1'b0, 32'h3000, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("t6_in_fill", {31'b0, mem_req}, 1);
    do_reset();
    check("t6_mem_req_after_reset", {31'b0, mem_req}, 0);
    check("t6_miss_after_reset", {31'b0, miss}, 0);
    lat_next = 3;
    r0 = req_cycles;
    access(1'b0, 32'h100, 4'h0, 32'h0, "t6_read");
    check("t6_read_missed", {31'b0, req_cycles != r0}, 1);

    // Random traffic over four tags x four sets to force conflicts and writebacks.
    rand_lat = 1'b1;
    repeat (400) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, "rand");
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
